// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: fetch-stage sequencer arbitrating redirect, load-use stall, imem wait and halt.
module fetch_hazard_ctrl #(
  parameter int INIT_CYCLES  = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exBranchTaken,
  input  logic [31:0]      exBranchAddr,
  input  logic             exMemRead,
  input  logic [4:0]       exRd,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             imemReady,
  input  logic             haltReq,
  output logic             pcSrc,
  output logic [31:0]      branchAddr,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             fetchErr,
  output logic [CNT_W-1:0] stallCount,
  output logic [2:0]       state
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES - 1);
  localparam logic [3:0]    FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(MEM_TIMEOUT);
  typedef enum logic [2:0] {S_INIT, S_RUN, S_FLUSH, S_WAIT, S_HALT, S_ERR} state_t;
  state_t cur, nxt;
  logic [IW-1:0] initCnt, initNxt;
  logic [3:0] flushCnt, flushNxt;
  logic [TW-1:0] toCnt, toNxt, toInc;
  logic loadUse, errSet;
  assign branchAddr = exBranchAddr;
  assign state = cur;
  assign toInc = toCnt + 1'b1;
  assign loadUse = exMemRead && exRd != 5'd0 && (exRd == idRs1 || exRd == idRs2);
  always_comb begin
    nxt = cur;
    pcSrc = 1'b0;
    pcWrite = 1'b0;
    ifidWrite = 1'b0;
    ifidFlush = 1'b0;
    idexBubble = 1'b0;
    initNxt = initCnt;
    flushNxt = flushCnt;
    toNxt = toCnt;
    errSet = 1'b0;
    case (cur)
      S_INIT: begin
        {pcWrite, ifidWrite, ifidFlush, idexBubble} = 4'b1111;
        initNxt = initCnt + 1'b1;
        nxt = initCnt == INIT_LAST ? S_RUN : S_INIT;
      end
      S_RUN, S_WAIT, S_FLUSH: begin
        if (exBranchTaken) begin
          {pcSrc, ifidFlush, idexBubble} = 3'b111;
          toNxt = '0;
          flushNxt = '0;
          nxt = FLUSH_CYCLES > 0 ? S_FLUSH : S_RUN;
        end else if (loadUse) begin
          {pcWrite, ifidWrite, idexBubble} = 3'b111;
        end else if (!imemReady) begin
          {pcWrite, ifidWrite} = 2'b11;
          toNxt = toInc;
          errSet = toInc >= TO_MAX;
          nxt = errSet ? S_ERR : S_WAIT;
        end else if (cur == S_FLUSH) begin
          ifidFlush = 1'b1;
          toNxt = '0;
          flushNxt = flushCnt + 1'b1;
          nxt = flushCnt == FLUSH_LAST ? S_RUN : S_FLUSH;
        end else begin
          toNxt = '0;
          nxt = haltReq ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        // a redirect still reaches the PC while halted; fetch stays frozen afterwards
        if (exBranchTaken) {pcSrc, ifidFlush, idexBubble} = 3'b111;
        else begin
          {pcWrite, ifidWrite, idexBubble} = 3'b111;
          nxt = haltReq ? S_HALT : S_RUN;
        end
      end
      S_ERR: {pcWrite, ifidWrite, idexBubble} = 3'b111;
      default: nxt = S_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_INIT;
      initCnt <= '0;
      flushCnt <= '0;
      toCnt <= '0;
      fetchErr <= 1'b0;
      stallCount <= '0;
    end else begin
      cur <= nxt;
      initCnt <= initNxt;
      flushCnt <= flushNxt;
      toCnt <= toNxt;
      if (errSet) fetchErr <= 1'b1;
      if (pcWrite && cur != S_INIT && !(&stallCount)) stallCount <= stallCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb_fetch_hazard_ctrl: directed checks of fetch sequencing, stalls, timeout and halt.
module tb_fetch_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic exBranchTaken = 1'b0, exMemRead = 1'b0, imemReady = 1'b1, haltReq = 1'b0;
  logic [31:0] exBranchAddr = '0, branchAddr;
  logic [4:0] exRd = '0, idRs1 = '0, idRs2 = '0;
  logic pcSrc, pcWrite, ifidWrite, ifidFlush, idexBubble, fetchErr;
  logic [15:0] stallCount;
  logic [2:0] state;
  int nChecks = 0, nPass = 0;
  fetch_hazard_ctrl dut (
    .clk(clk), .reset(reset), .exBranchTaken(exBranchTaken), .exBranchAddr(exBranchAddr),
    .exMemRead(exMemRead), .exRd(exRd), .idRs1(idRs1), .idRs2(idRs2), .imemReady(imemReady),
    .haltReq(haltReq), .pcSrc(pcSrc), .branchAddr(branchAddr), .pcWrite(pcWrite),
    .ifidWrite(ifidWrite), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .fetchErr(fetchErr), .stallCount(stallCount), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("init_hold", {29'd0, state, pcWrite}, {29'd0, 3'd0, 1'b1});
      tick();
    end
  endtask
  initial begin
    tick();
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_stall", stallCount, 0);
    check("rst_err", fetchErr, 0);
    check("init_outs", {pcWrite, ifidWrite, ifidFlush, idexBubble, pcSrc}, 5'b11110);
    for (int i = 0; i < 4; i++) begin
      check("init_hold", {29'd0, state, pcWrite}, {29'd0, 3'd0, 1'b1});
      tick();
    end
    check("run_state", state, 1);
    check("run_outs", {pcWrite, ifidWrite, ifidFlush, idexBubble, pcSrc}, 5'b00000);
    check("run_stall", stallCount, 0);
    exBranchTaken = 1'b1; exBranchAddr = 32'h100; #1;
    check("redir_outs", {pcSrc, pcWrite, ifidFlush, idexBubble}, 4'b1011);
    check("redir_addr", branchAddr, 32'h100);
    tick();
    exBranchTaken = 1'b0; #1;
    check("flush_state", state, 2);
    check("flush_outs", {ifidFlush, idexBubble, pcWrite, pcSrc}, 4'b1000);
    tick();
    check("flush_done", {29'd0, state}, 1);
    check("flush_off", ifidFlush, 0);
    exMemRead = 1'b1; exRd = 5'd5; idRs1 = 5'd3; idRs2 = 5'd5; #1;
    check("lu_outs", {pcWrite, ifidWrite, idexBubble, pcSrc}, 4'b1110);
    tick();
    check("lu_state", state, 1);
    check("lu_stall", stallCount, 1);
    exRd = 5'd0; idRs2 = 5'd0; #1;
    check("lu_r0", {pcWrite, idexBubble}, 2'b00);
    exRd = 5'd5; idRs2 = 5'd5; exBranchTaken = 1'b1; #1;
    check("redir_vs_lu", {pcSrc, pcWrite, idexBubble, ifidFlush}, 4'b1011);
    tick();
    exBranchTaken = 1'b0; exMemRead = 1'b0;
    tick();
    check("prio_back_run", state, 1);
    check("prio_stall", stallCount, 1);
    imemReady = 1'b0; #1;
    check("imem_hold", {pcWrite, ifidWrite}, 2'b11);
    for (int i = 0; i < 3; i++) tick();
    check("wait_state", state, 3);
    check("wait_stall", stallCount, 4);
    imemReady = 1'b1; #1;
    check("wait_release", {pcWrite, ifidWrite}, 2'b00);
    tick();
    check("wait_to_run", state, 1);
    imemReady = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    check("to_not_yet", {state, fetchErr}, {3'd3, 1'b0});
    tick();
    check("to_err_state", state, 5);
    check("to_err_flag", fetchErr, 1);
    check("to_stall", stallCount, 68);
    imemReady = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("err_sticky", {state, fetchErr, pcWrite}, {3'd5, 1'b1, 1'b1});
    doReset();
    check("err_cleared", {state, fetchErr}, {3'd1, 1'b0});
    check("err_stall0", stallCount, 0);
    haltReq = 1'b1; #1;
    check("halt_req_run", pcWrite, 0);
    tick();
    check("halt_state", state, 4);
    check("halt_outs", {pcWrite, ifidWrite, idexBubble}, 3'b111);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_rst_state", state, 0);
    check("halt_rst_err", fetchErr, 0);
    check("halt_rst_stall", stallCount, 0);
    for (int i = 0; i < 4; i++) tick();
    check("halt2_run", state, 1);
    tick();
    check("halt2_state", state, 4);
    exBranchTaken = 1'b1; #1;
    check("halt_redir", {pcSrc, pcWrite}, 2'b10);
    tick();
    exBranchTaken = 1'b0; haltReq = 1'b0; #1;
    check("halt_after_redir", {state, pcWrite}, {3'd4, 1'b1});
    tick();
    check("halt_exit", state, 1);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
